dec_ram_ctrl: RTL and testbench

Ping-pong controller for the two-bank hard-decision RAM that sits between the LDPC decoder core and the codeword output stream. The decoder writes hard-decision bits of frame N into one bank while the output streamer reads frame N-1 from the other. Both banks share a single address bus, so the block arbitrates that bus cycle by cycle between writer and reader. A bank swaps role only when its frame is complete.

---
 rtl/dec_ram_ctrl_if.sv | 40 ++++
 rtl/dec_ram_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_dec_ram_ctrl.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dec_ram_ctrl_if.sv
// Decoder write handshake and output stream bundle for dec_ram_ctrl.
// master drives writes and out_ready; slave is the controller.
interface dec_ram_ctrl_if #(
  parameter int DATA_WIDTH = 1,
  parameter int ADDR_WIDTH = 8
);
  logic                  wr_valid;
  logic                  wr_ready;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_last;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_last;

  modport master (
    output wr_valid,
    output wr_addr,
    output wr_data,
    output wr_last,
    output out_ready,
    input  wr_ready,
    input  out_valid,
    input  out_data,
    input  out_last
  );

  modport slave (
    input  wr_valid,
    input  wr_addr,
    input  wr_data,
    input  wr_last,
    input  out_ready,
    output wr_ready,
    output out_valid,
    output out_data,
    output out_last
  );
endinterface

// File: rtl/dec_ram_ctrl.sv
// Ping-pong controller for the two-bank hard-decision RAM.
// DEC_RAM_CTRL_RR_ARB_EN: round-robin bus arbitration, else write priority.
module dec_ram_ctrl #(
  parameter int DATA_WIDTH = 1,
  parameter int ADDR_WIDTH = 8,
  parameter int FRAME_LEN  = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  dec_ram_ctrl_if.slave         bus,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic [DATA_WIDTH-1:0] ram_data_in [0:1],
  output logic                  ram_we [0:1],
  output logic                  ram_cs [0:1],
  output logic                  ram_rs,
  input  logic [DATA_WIDTH-1:0] ram_data_out [0:1],
  output logic [1:0]            bank_full,
  output logic                  wr_addr_err
);

  localparam logic [ADDR_WIDTH:0] FLEN =
    (ADDR_WIDTH+1)'(FRAME_LEN);
  localparam logic [ADDR_WIDTH-1:0] LAST_PTR =
    ADDR_WIDTH'(FRAME_LEN - 1);

  logic                  wb_q, wb_d;
  logic                  rb_q, rb_d;
  logic [1:0]            full_q, full_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic                  err_q, err_d;

  logic [DATA_WIDTH-1:0] fifo_data_q [0:1];
  logic [1:0]            fifo_last_q;
  logic                  fifo_wp_q;
  logic                  fifo_rp_q;
  logic [1:0]            fifo_cnt_q, fifo_cnt_d;

  logic                  infl_q;
  logic                  infl_bank_q;
  logic                  infl_last_q;

  logic                  wr_req;
  logic                  rd_req;
  logic                  gnt_wr;
  logic                  gnt_rd;
  logic                  pop;
  logic                  in_range;
  logic                  rd_wrap;
  logic [2:0]            occ;

  assign pop      = !rst && (fifo_cnt_q != 2'd0)
                    && bus.out_ready;
  assign in_range = {1'b0, bus.wr_addr} < FLEN;
  assign rd_wrap  = rd_ptr_q == LAST_PTR;

  // Counting the pop lets a slot freed this cycle be refilled at once.
  assign occ = {1'b0, fifo_cnt_q} + {2'b0, infl_q}
               - {2'b0, pop};

  assign wr_req = !rst && bus.wr_valid && !full_q[wb_q];
  assign rd_req = !rst && full_q[rb_q] && (occ < 3'd2);

`ifdef DEC_RAM_CTRL_RR_ARB_EN
  localparam logic [0:0] ARB_WR = 1'b0;
  localparam logic [0:0] ARB_RD = 1'b1;

  logic [0:0] arb_q, arb_d;

  assign gnt_wr = wr_req && (!rd_req || arb_q == ARB_WR);
  assign gnt_rd = rd_req && (!wr_req || arb_q == ARB_RD);

  always_comb begin
    arb_d = arb_q;
    if (wr_req && rd_req)
      arb_d = gnt_wr ? ARB_RD : ARB_WR;
  end

  always_ff @(posedge clk) begin
    if (rst) arb_q <= ARB_WR;
    else     arb_q <= arb_d;
  end
`else
  assign gnt_wr = wr_req;
  assign gnt_rd = rd_req && !wr_req;
`endif

  always_comb begin
    ram_address    = '0;
    ram_data_in[0] = '0;
    ram_data_in[1] = '0;
    ram_we[0]      = 1'b0;
    ram_we[1]      = 1'b0;
    ram_cs[0]      = 1'b0;
    ram_cs[1]      = 1'b0;
    ram_rs         = 1'b0;
    if (gnt_wr) begin
      ram_address         = bus.wr_addr;
      ram_rs              = wb_q;
      ram_data_in[wb_q]   = bus.wr_data;
      if (in_range) begin
        ram_cs[wb_q]      = 1'b1;
        ram_we[wb_q]      = 1'b1;
      end
    end else if (gnt_rd) begin
      ram_address  = rd_ptr_q;
      ram_rs       = rb_q;
      ram_cs[rb_q] = 1'b1;
    end
  end

  always_comb begin
    wb_d     = wb_q;
    rb_d     = rb_q;
    full_d   = full_q;
    rd_ptr_d = rd_ptr_q;
    err_d    = err_q;
    if (gnt_wr) begin
      if (!in_range) err_d = 1'b1;
      if (bus.wr_last) begin
        full_d[wb_q] = 1'b1;
        wb_d         = ~wb_q;
      end
    end
    if (gnt_rd) begin
      if (rd_wrap) begin
        rd_ptr_d     = '0;
        full_d[rb_q] = 1'b0;
        rb_d         = ~rb_q;
      end else begin
        rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
      end
    end
  end

  always_comb begin
    fifo_cnt_d = fifo_cnt_q;
    unique case (1'b1)
      infl_q && !pop: fifo_cnt_d = fifo_cnt_q + 2'd1;
      !infl_q && pop: fifo_cnt_d = fifo_cnt_q - 2'd1;
      default:        fifo_cnt_d = fifo_cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_q           <= 1'b0;
      rb_q           <= 1'b0;
      full_q         <= 2'b00;
      rd_ptr_q       <= '0;
      err_q          <= 1'b0;
      fifo_data_q[0] <= '0;
      fifo_data_q[1] <= '0;
      fifo_last_q    <= 2'b00;
      fifo_wp_q      <= 1'b0;
      fifo_rp_q      <= 1'b0;
      fifo_cnt_q     <= 2'd0;
      infl_q         <= 1'b0;
      infl_bank_q    <= 1'b0;
      infl_last_q    <= 1'b0;
    end else begin
      wb_q        <= wb_d;
      rb_q        <= rb_d;
      full_q      <= full_d;
      rd_ptr_q    <= rd_ptr_d;
      err_q       <= err_d;
      fifo_cnt_q  <= fifo_cnt_d;
      infl_q      <= gnt_rd;
      infl_bank_q <= rb_q;
      infl_last_q <= rd_wrap;
      // RAM data of last cycle's read is valid now.
      if (infl_q) begin
        fifo_data_q[fifo_wp_q] <= ram_data_out[infl_bank_q];
        fifo_last_q[fifo_wp_q] <= infl_last_q;
        fifo_wp_q              <= ~fifo_wp_q;
      end
      if (pop) fifo_rp_q <= ~fifo_rp_q;
    end
  end

  assign bus.wr_ready  = gnt_wr;
  assign bus.out_valid = !rst && (fifo_cnt_q != 2'd0);
  assign bus.out_data  = rst ? '0 : fifo_data_q[fifo_rp_q];
  assign bus.out_last  = !rst && fifo_last_q[fifo_rp_q];
  assign bank_full     = rst ? 2'b00 : full_q;
  assign wr_addr_err   = !rst && err_q;

endmodule

// File: tb/tb_dec_ram_ctrl.sv
// Scoreboard bench for dec_ram_ctrl with a behavioural two-bank RAM.
// Frames are queued as expected words at commit; a monitor checks the stream.
module tb_dec_ram_ctrl;
  localparam int DW = 1;
  localparam int AW = 9;
  localparam int FL = 256;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dec_ram_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  logic [AW-1:0] ram_address;
  logic [DW-1:0] ram_data_in [0:1];
  logic          ram_we [0:1];
  logic          ram_cs [0:1];
  logic          ram_rs;
  logic [DW-1:0] ram_data_out [0:1];
  logic [1:0]    bank_full;
  logic          wr_addr_err;

  dec_ram_ctrl #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FRAME_LEN(FL)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .ram_address(ram_address),
    .ram_data_in(ram_data_in),
    .ram_we(ram_we),
    .ram_cs(ram_cs),
    .ram_rs(ram_rs),
    .ram_data_out(ram_data_out),
    .bank_full(bank_full),
    .wr_addr_err(wr_addr_err)
  );

  logic [DW-1:0] mem [2][512];
  always @(posedge clk) begin
    for (int b = 0; b < 2; b++) begin
      if (ram_cs[b]) begin
        if (ram_we[b]) mem[b][ram_address] <= ram_data_in[b];
        else           ram_data_out[b] <= mem[b][ram_address];
      end
    end
  end

  int vectors = 0;
  int miscompares = 0;
  int pop_cnt = 0;
  bit writer_done;
  bit [1:0] exp_q [$];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic pat(int f, int i);
    logic [31:0] iv, fv;
    iv = i;
    fv = f;
    if (fv == 0) return iv[0];
    return iv[0] ^ iv[(fv % 3) + 1] ^ fv[0];
  endfunction

  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      bit [1:0] e;
      pop_cnt++;
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL stream_extra: got word %b/%b expected none",
                 bus.out_data, bus.out_last);
      end else begin
        e = exp_q.pop_front();
        if ({bus.out_data, bus.out_last} !== e) begin
          miscompares++;
          $display("FAIL stream_word: got data/last %b%b expected %b",
                   bus.out_data, bus.out_last, e);
        end
      end
    end
  end

  task automatic write_word(int addr, logic d, logic last,
                            output logic bank);
    bit ok = 0;
    bus.wr_valid = 1'b1;
    bus.wr_addr  = AW'(addr);
    bus.wr_data  = d;
    bus.wr_last  = last;
    bank = 1'b0;
    for (int n = 0; n < 4000; n++) begin
      @(negedge clk);
      if (bus.wr_ready) begin
        bank = ram_rs;
        ok = 1;
        break;
      end
    end
    @(posedge clk);
    #1;
    bus.wr_valid = 1'b0;
    bus.wr_last  = 1'b0;
    if (!ok) chk("write_timeout", 0, 1);
  endtask

  task automatic write_frame(int f, output logic fb, output logic lb);
    logic b;
    fb = 1'b0;
    for (int i = 0; i < FL; i++) begin
      write_word(i, pat(f, i), i == FL - 1, b);
      if (i == 0) fb = b;
    end
    lb = b;
    for (int i = 0; i < FL; i++)
      exp_q.push_back({pat(f, i), i == FL - 1});
  endtask

  task automatic wait_drain(string name);
    for (int n = 0; n < 3000; n++) begin
      @(posedge clk);
      if (exp_q.size() == 0) break;
    end
    #1;
    chk(name, exp_q.size(), 0);
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    bus.wr_valid  = 1'b0;
    bus.wr_last   = 1'b0;
    bus.out_ready = 1'b0;
    exp_q.delete();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic chk_first_read(string name);
    @(negedge clk);
    chk(name, {ram_cs[0], ram_cs[1], ram_we[0], ram_rs, ram_address},
        {1'b1, 1'b0, 1'b0, 1'b0, 9'd0});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic fb, lb, b3, is_wr, is_rd, prev_wr, found;
    int k, p0;
    rst = 1'b1;
    bus.wr_valid  = 1'b0;
    bus.wr_addr   = '0;
    bus.wr_data   = '0;
    bus.wr_last   = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 bus.wr_valid = 1'b1;
    @(negedge clk);
    chk("rst_wr_ready", bus.wr_ready, 0);
    chk("rst_out", {bus.out_valid, bus.out_data, bus.out_last}, 0);
    chk("rst_bank_full", bank_full, 0);
    chk("rst_err", wr_addr_err, 0);
    chk("rst_ram_ctl", {ram_cs[0], ram_cs[1], ram_we[0], ram_we[1]}, 0);
    @(posedge clk);
    #1;
    bus.wr_valid = 1'b0;
    rst = 1'b0;

    // single frame, latency and stream
    bus.out_ready = 1'b1;
    write_frame(0, fb, lb);
    chk("t1_bank_full", bank_full, 2'b01);
    chk("t1_banks", {fb, lb}, 2'b00);
    chk("t1_out_valid_e0", bus.out_valid, 0);
    chk_first_read("t1_first_read");
    @(posedge clk); #1;
    chk("t1_out_valid_e1", bus.out_valid, 0);
    @(posedge clk); #1;
    chk("t1_out_valid_e2", bus.out_valid, 1);
    wait_drain("t1_drain");
    repeat (3) @(posedge clk);
    #1;
    chk("t1_idle", {bank_full, bus.out_valid}, 0);

    // both banks full, writer stalls
    reset_dut();
    writer_done = 0;
    fork
      begin
        logic a, z;
        write_frame(1, a, z);
        write_frame(2, a, z);
        write_frame(3, b3, z);
        writer_done = 1;
      end
    join_none
    for (int n = 0; n < 2000; n++) begin
      @(posedge clk);
      if (bank_full == 2'b11) break;
    end
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("t2_bank_full", bank_full, 2'b11);
    chk("t2_wr_stall", bus.wr_ready, 0);
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      @(posedge clk);
      if (writer_done) break;
    end
    #1;
    chk("t2_writer_done", writer_done, 1);
    chk("t2_frame2_bank", b3, 0);
    wait_drain("t2_drain");

    // writer and reader in conflict
    reset_dut();
    bus.out_ready = 1'b1;
    write_frame(4, fb, lb);
    k = 0;
    prev_wr = 1'b0;
    bus.wr_valid = 1'b1;
    bus.wr_addr  = '0;
    bus.wr_data  = pat(5, 0);
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      is_wr = bus.wr_ready;
      is_rd = !bus.wr_ready && (ram_cs[0] || ram_cs[1])
              && !ram_we[0] && !ram_we[1];
`ifdef DEC_RAM_CTRL_RR_ARB_EN
      if (c == 0) chk("t3_rr_first", {is_wr, is_rd}, 2'b10);
      else chk("t3_rr_alt", {is_wr, is_rd},
               prev_wr ? 2'b01 : 2'b10);
`else
      chk("t3_fix_wr_only", {is_wr, is_rd}, 2'b10);
`endif
      prev_wr = is_wr;
      @(posedge clk);
      #1;
      if (is_wr) k++;
      bus.wr_addr = AW'(k);
      bus.wr_data = pat(5, k);
    end
    bus.wr_valid = 1'b0;
    found = 1'b0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if ((ram_cs[0] || ram_cs[1]) && !ram_we[0] && !ram_we[1]) begin
        found = 1'b1;
        break;
      end
    end
    chk("t3_read_resume", found, 1);
    wait_drain("t3_drain");

    // backpressure toggling
    reset_dut();
    write_frame(6, fb, lb);
    p0 = pop_cnt;
    for (int n = 0; n < 3000; n++) begin
      @(posedge clk);
      #1 bus.out_ready = ~bus.out_ready;
      if (exp_q.size() == 0) break;
    end
    chk("t4_drain", exp_q.size(), 0);
    chk("t4_words", pop_cnt - p0, FL);
    bus.out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("t4_idle", bus.out_valid, 0);

    // out-of-range write address
    reset_dut();
    chk("t5_err_clear", wr_addr_err, 0);
    bus.wr_valid = 1'b1;
    bus.wr_addr  = AW'(300);
    bus.wr_data  = 1'b1;
    bus.wr_last  = 1'b0;
    @(negedge clk);
    chk("t5_accept", bus.wr_ready, 1);
    chk("t5_cs_we", {ram_cs[0], ram_cs[1], ram_we[0], ram_we[1]}, 0);
    @(posedge clk);
    #1 bus.wr_valid = 1'b0;
    chk("t5_err_set", wr_addr_err, 1);
    repeat (5) @(posedge clk);
    write_word(5, 1'b0, 1'b0, fb);
    chk("t5_err_held", wr_addr_err, 1);
    chk("t5_bank_full", bank_full, 0);
    reset_dut();
    chk("t5_err_rst", wr_addr_err, 0);

    // reset mid-stream
    bus.out_ready = 1'b1;
    p0 = pop_cnt;
    write_frame(7, fb, lb);
    for (int n = 0; n < 1000; n++) begin
      @(posedge clk);
      if (pop_cnt - p0 >= 100) break;
    end
    #1;
    chk("t6_words_before", pop_cnt - p0, 100);
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    chk("t6_after_rst", {bus.out_valid, bank_full}, 0);
    write_frame(8, fb, lb);
    chk("t6_bank0", {fb, lb}, 0);
    chk_first_read("t6_first_read");
    wait_drain("t6_drain");

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end
endmodule
